// File: rtl/cl_div_seq_if.sv
// Operand/result bundle for the carry-less divider.
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds its payload
// stable while valid is high and ready is low; the consumer may drive ready
// freely.
interface cl_div_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [2*DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0]   b;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0]   r;
  logic                    div_by_zero;

  // Requester side: supplies operands and accepts results.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, r, div_by_zero
  );

  // Divider side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, r, div_by_zero
  );
endinterface

// File: rtl/cl_div_seq.sv
// Sequential carry-less (GF(2)[x]) polynomial divider.
// The divisor is first normalised so its top bit is set (shifted left k
// times), then a bit-serial long division runs over the dividend followed
// by k zero bits, i.e. over a*x^k. The quotient is unchanged by that
// scaling; the remainder comes out scaled by x^k and is shifted back.
module cl_div_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  cl_div_seq_if.slave   bus,
  output logic [1:0]    dbg_state
);

  localparam int N  = DATA_WIDTH;
  localparam int KW = $clog2(N);
  localparam int CW = $clog2(3 * N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2*N-1:0]  s_q, s_d;      // dividend bits still to be consumed
  logic [N-1:0]    dn_q, dn_d;    // normalised divisor
  logic [KW-1:0]   k_q, k_d;      // normalisation shift count
  logic [N-2:0]    rem_q, rem_d;  // running partial remainder
  logic [2*N-1:0]  quo_q, quo_d;  // running quotient
  logic [CW-1:0]   cnt_q, cnt_d;  // division steps left
  logic [2*N-1:0]  q_q, q_d;      // published quotient
  logic [N-1:0]    r_q, r_d;      // published remainder
  logic            dz_q, dz_d;    // published divide-by-zero flag

  // One division step, evaluated every cycle but only used in ST_DIV.
  logic            bit_in;
  logic [N-1:0]    t_w;
  logic [N-1:0]    t_x;
  logic [N-2:0]    rem_step;
  logic [2*N-1:0]  quo_step;

  assign bit_in   = s_q[2*N-1];
  assign t_w      = {rem_q, bit_in};
  assign t_x      = t_w[N-1] ? (t_w ^ dn_q) : t_w;
  assign rem_step = t_x[N-2:0];
  assign quo_step = {quo_q[2*N-2:0], t_w[N-1]};

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    dn_d    = dn_q;
    k_d     = k_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (bus.b == '0) begin
            q_d     = '0;
            r_d     = '0;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            s_d     = bus.a;
            dn_d    = bus.b;
            k_d     = '0;
            dz_d    = 1'b0;
            state_d = ST_NORM;
          end
        end
      end

      ST_NORM: begin
        if (dn_q[N-1]) begin
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CW'(2 * N) + CW'(k_q);
          state_d = ST_DIV;
        end else begin
          dn_d = dn_q << 1;
          k_d  = k_q + KW'(1);
        end
      end

      ST_DIV: begin
        s_d   = s_q << 1;
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = quo_step;
          // Undo the x^k scaling introduced by normalisation.
          r_d     = {1'b0, rem_step} >> k_q;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Handshake edge returns to idle; accepting again waits a cycle.
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      dn_q    <= '0;
      k_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      dn_q    <= dn_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.out_valid   = (state_q == ST_DONE);
  assign bus.q           = q_q;
  assign bus.r           = r_q;
  assign bus.div_by_zero = dz_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_cl_div_seq.sv
// Directed and randomised bench for cl_div_seq at DATA_WIDTH = 8.
module tb_cl_div_seq;

  localparam int N       = 8;
  localparam int MAX_LAT = 200;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  cl_div_seq_if #(.DATA_WIDTH(N)) bus ();

  cl_div_seq #(.DATA_WIDTH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Expected {q, r, div_by_zero} for directed vectors, in issue order.
  logic [2*N+N:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference helpers ----------------
  function automatic logic [31:0] clmul(input logic [7:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) p = p ^ (32'(y) << i);
    end
    return p;
  endfunction

  function automatic int deg8(input logic [7:0] x);
    int d;
    d = 0;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) d = i;
    end
    return d;
  endfunction

  // Edges from the accept edge (counted as 1) to out_valid seen high.
  function automatic int exp_latency(input logic [7:0] b_i);
    if (b_i == 8'h00) return 1;
    return 2 * N + 2 * (N - 1 - deg8(b_i)) + 2;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accept edge, then wait for out_valid.
  task automatic apply_op(input logic [15:0] a_i, input logic [7:0] b_i, output int lat);
    bus.a        = a_i;
    bus.b        = b_i;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < MAX_LAT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_directed(input string name, input logic [15:0] a_i, input logic [7:0] b_i,
                              input logic [15:0] eq, input logic [7:0] er, input logic edz);
    int lat;
    logic [2*N+N:0] e;
    exp_q.push_back({eq, er, edz});
    apply_op(a_i, b_i, lat);
    e = exp_q.pop_front();
    check({name, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, ".latency"}, 32'(lat), 32'(exp_latency(b_i)));
    check({name, ".q"}, 32'(bus.q), 32'(e[2*N+N:N+1]));
    check({name, ".r"}, 32'(bus.r), 32'(e[N:1]));
    check({name, ".dz"}, 32'(bus.div_by_zero), 32'(e[0]));
    consume();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [15:0] ra;
    logic [7:0]  rb;

    n_vec = 0;
    n_err = 0;
    do_reset();

    check("reset.in_ready",  32'(bus.in_ready),    32'd1);
    check("reset.out_valid", 32'(bus.out_valid),   32'd0);
    check("reset.q",         32'(bus.q),           32'd0);
    check("reset.r",         32'(bus.r),           32'd0);
    check("reset.dz",        32'(bus.div_by_zero), 32'd0);
    check("reset.state",     32'(dbg_state),       32'd0);

    // (x^4+1)/(x+1) = x^3+x^2+x+1, deg(b)=1 so k=6.
    run_directed("v1", 16'h0011, 8'h03, 16'h000F, 8'h00, 1'b0);
    // Divisor x^7: quotient is a>>7, remainder the low 7 bits; k=0.
    run_directed("v2", 16'h1234, 8'h80, 16'h0024, 8'h34, 1'b0);
    // Zero divisor short-circuits straight to DONE.
    run_directed("v4", 16'hABCD, 8'h00, 16'h0000, 8'h00, 1'b1);
    // Divide by 1: q=a, k=7; also shows div_by_zero clears again.
    run_directed("v3", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0);
    // (x^2+1)/(x+1) = x+1 exactly.
    run_directed("v5", 16'h0005, 8'h03, 16'h0003, 8'h00, 1'b0);
    // Dividend of lower degree than divisor: q=0, r=a.
    run_directed("v6", 16'h0007, 8'h0B, 16'h0000, 8'h07, 1'b0);

    // Held result: x^8 = (x^4+1)^2 + 1, so q=0x11, r=0x01.
    apply_op(16'h0100, 8'h11, lat);
    check("hold.latency", 32'(lat), 32'(exp_latency(8'h11)));
    for (int i = 0; i < 10; i++) begin
      bus.a        = 16'($urandom_range(0, 65535));
      bus.b        = 8'($urandom_range(1, 255));
      bus.in_valid = i[0];
      @(posedge clk);
      #1;
      check("hold.out_valid", 32'(bus.out_valid), 32'd1);
      check("hold.in_ready",  32'(bus.in_ready),  32'd0);
      check("hold.q",         32'(bus.q),         32'h0011);
      check("hold.r",         32'(bus.r),         32'h01);
    end
    // Operands offered on the handshake edge itself must not be taken.
    bus.a         = 16'h0005;
    bus.b         = 8'h03;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("hs.out_valid", 32'(bus.out_valid), 32'd0);
    check("hs.in_ready",  32'(bus.in_ready),  32'd1);
    check("hs.q_kept",    32'(bus.q),         32'h0011);
    check("hs.r_kept",    32'(bus.r),         32'h01);
    @(posedge clk);
    #1;
    check("hs.still_idle", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a division.
    bus.a        = 16'h1234;
    bus.b        = 8'h80;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort.in_div", 32'(dbg_state), 32'd2);
    rst_n = 1'b0;
    #1;
    check("abort.in_ready",  32'(bus.in_ready),    32'd1);
    check("abort.out_valid", 32'(bus.out_valid),   32'd0);
    check("abort.q",         32'(bus.q),           32'd0);
    check("abort.r",         32'(bus.r),           32'd0);
    check("abort.dz",        32'(bus.div_by_zero), 32'd0);
    check("abort.state",     32'(dbg_state),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random operands checked against the defining identity.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 8'($urandom_range(1, 255));
      apply_op(ra, rb, lat);
      check("rnd.latency", 32'(lat), 32'(exp_latency(rb)));
      check("rnd.identity", clmul(rb, bus.q) ^ 32'(bus.r), 32'(ra));
      check("rnd.rdeg", 32'(bus.r >> deg8(rb)), 32'd0);
      consume();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
